// File: rtl/array_accum_pkg.sv
// array_accum_pkg
//   Shared constants and types for the array_accum dot-product accumulator.
//   W_DEF / N_DEF     : default lane data width and lane count
//   ACC_GUARD         : guard bits the accumulator carries above W
//   ACC_W_DEF         : default accumulator width (W + guard)
//   state_t           : control FSM states
//   tree_w()          : output width of the pipelined adder tree
package array_accum_pkg;

    localparam int W_DEF     = 45;
    localparam int N_DEF     = 4;
    localparam int ACC_GUARD = 3;
    localparam int ACC_W_DEF = W_DEF + ACC_GUARD;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,   // accepting beats
        DRAIN = 2'd1,   // last beat travelling through the adder tree
        HOLD  = 2'd2    // completed result presented downstream
    } state_t;

    // Each tree level adds one bit of growth; lanes must be a power of two >= 4.
    function automatic int tree_w(input int w, input int lanes);
        return w + $clog2(lanes);
    endfunction

endpackage

// File: rtl/array_accum_if.sv
// array_accum_if
//   Handshake bundle between the array multiplier, the accumulator and the
//   downstream consumer. The products side matches the multiplier's result
//   bus so the two stages connect directly.
//   master : drives in_valid, in_last, products, out_ready
//   slave  : drives in_ready, out_valid, out_sum, out_sat (the accumulator)
interface array_accum_if
    import array_accum_pkg::*;
#(
    parameter int n = N_DEF,
    parameter int W = W_DEF
);

    logic                in_valid;
    logic                in_last;
    logic [n-1:0][W-1:0] products;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_sum;
    logic                out_sat;

    modport master (
        output in_valid, in_last, products, out_ready,
        input  in_ready, out_valid, out_sum, out_sat
    );

    modport slave (
        input  in_valid, in_last, products, out_ready,
        output in_ready, out_valid, out_sum, out_sat
    );

endinterface

// File: rtl/array_accum_add_tree_pipe.sv
// add_tree_pipe
//   Two-stage registered adder tree reducing n signed lanes to one sum.
//   Stage 1 adds lane pairs at W+1 bits; stage 2 adds the pair sums.
//   Ports:
//     clk, rst, en : clock, sync active-high reset, global enable (freeze)
//     vld_p0       : beat accepted this cycle
//     last_p0      : accepted beat closes the dot product
//     products     : n lanes of W-bit signed products
//     vld_p2       : sum_p2 holds a beat sum
//     last_p2      : that beat was the last of its dot product
//     sum_p2       : TW-bit signed beat sum
module add_tree_pipe
    import array_accum_pkg::*;
#(
    parameter int n  = N_DEF,
    parameter int W  = W_DEF,
    parameter int TW = tree_w(W, n)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  vld_p0,
    input  logic                  last_p0,
    input  logic [n-1:0][W-1:0]   products,
    output logic                  vld_p2,
    output logic                  last_p2,
    output logic signed [TW-1:0]  sum_p2
);

    localparam int PAIRS = n / 2;

    logic signed [W:0]    pair_sum [PAIRS];
    logic signed [W:0]    sum_p1   [PAIRS];
    logic                 vld_p1;
    logic                 last_p1;
    logic signed [TW-1:0] tot;

    always_comb begin
        for (int i = 0; i < PAIRS; i++) begin
            pair_sum[i] = {products[2*i][W-1], products[2*i]}
                        + {products[2*i+1][W-1], products[2*i+1]};
        end
    end

    always_comb begin
        tot = '0;
        for (int i = 0; i < PAIRS; i++) begin
            tot = tot + TW'(sum_p1[i]);
        end
    end

    // stage 0 -> stage 1: lane pair sums
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            for (int i = 0; i < PAIRS; i++) begin
                sum_p1[i] <= '0;
            end
        end else if (en) begin
            vld_p1  <= vld_p0;
            last_p1 <= vld_p0 & last_p0;
            for (int i = 0; i < PAIRS; i++) begin
                sum_p1[i] <= pair_sum[i];
            end
        end
    end

    // stage 1 -> stage 2: full beat sum
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
            sum_p2  <= '0;
        end else if (en) begin
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
            sum_p2  <= tot;
        end
    end

endmodule

// File: rtl/array_accum.sv
// array_accum
//   Accumulates beats of n lane products into a saturated signed dot product.
//   Beats flow through a 2-stage adder tree into a W+3 bit accumulator; the
//   result is held until the consumer takes it.
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset
//     en   : global enable; low freezes all state and blocks handshakes
//     bus  : slave side of array_accum_if (beats in, result out)
module array_accum
    import array_accum_pkg::*;
#(
    parameter int n = N_DEF,
    parameter int W = W_DEF
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    array_accum_if.slave  bus
);

    localparam int TW    = tree_w(W, n);
    localparam int ACC_W = W + ACC_GUARD;
    localparam int ACC_X = ACC_W + 1;

    state_t                  state;
    state_t                  state_next;
    logic                    take;
    logic                    vld_p2;
    logic                    last_p2;
    logic signed [TW-1:0]    sum_p2;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_X-1:0] acc_sum;
    logic                    acc_ovf;
    logic                    first;
    logic                    sticky;

    // Clamp a one-bit-wide accumulator sum back into the accumulator range.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_X-1:0] v);
        if (v[ACC_X-1] != v[ACC_W-1]) begin
            return v[ACC_X-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return v[ACC_W-1:0];
    endfunction

    // True when the accumulator is representable in W signed bits.
    function automatic logic fits_w(input logic signed [ACC_W-1:0] v);
        return (v[ACC_W-1:W-1] == '0) || (&v[ACC_W-1:W-1]);
    endfunction

    function automatic logic [W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        if (fits_w(v)) begin
            return v[W-1:0];
        end
        return v[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction

    assign take = en & bus.in_valid & bus.in_ready;

    add_tree_pipe #(
        .n  (n),
        .W  (W),
        .TW (TW)
    ) u_tree (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .vld_p0   (take),
        .last_p0  (bus.in_last),
        .products (bus.products),
        .vld_p2   (vld_p2),
        .last_p2  (last_p2),
        .sum_p2   (sum_p2)
    );

    assign acc_sum = ACC_X'(acc) + ACC_X'(sum_p2);
    assign acc_ovf = acc_sum[ACC_X-1] ^ acc_sum[ACC_W-1];

    // stage 2 -> accumulator; the first beat of a product overwrites rather
    // than adds, so no separate clear cycle is needed between products.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            first  <= 1'b1;
            sticky <= 1'b0;
        end else if (en && vld_p2) begin
            if (first) begin
                acc    <= ACC_W'(sum_p2);
                sticky <= 1'b0;
            end else begin
                acc    <= sat_acc(acc_sum);
                sticky <= sticky | acc_ovf;
            end
            first <= last_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else if (en) begin
            state <= state_next;
        end
    end

    // The ACCUM exit needs no en term: state only advances when en is high,
    // and in_ready is high throughout ACCUM, so in_valid marks an acceptance.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_sat   = 1'b0;
        bus.out_sum   = sat_out(acc);
        case (state)
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (vld_p2 && last_p2) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                bus.out_sat   = sticky | ~fits_w(acc);
                if (bus.out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

endmodule

// File: tb/tb_array_accum.sv
// tb_array_accum
//   Directed and randomized stimulus for array_accum, checked against a
//   running-sum model that works on whole integers with range clamping.
`timescale 1ns/1ps
module tb_array_accum;

    localparam int n = 4;
    localparam int W = 45;

    localparam longint ACC_HI = (64'sd1 <<< (W + 2)) - 64'sd1;
    localparam longint ACC_LO = -(64'sd1 <<< (W + 2));
    localparam longint OUT_HI = (64'sd1 <<< (W - 1)) - 64'sd1;
    localparam longint OUT_LO = -(64'sd1 <<< (W - 1));

    logic clk = 1'b0;
    logic rst;
    logic en;

    array_accum_if #(.n(n), .W(W)) bus ();

    array_accum #(.n(n), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint m_acc  = 0;
    bit     m_flag = 0;
    bit     m_first = 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a dot product is the running integer sum of its beat sums,
    // clamped to the accumulator range whenever it leaves it.
    function automatic void model_beat(input longint s);
        if (m_first) begin
            m_acc  = s;
            m_flag = 1'b0;
        end else begin
            m_acc = m_acc + s;
            if (m_acc > ACC_HI) begin
                m_acc  = ACC_HI;
                m_flag = 1'b1;
            end else if (m_acc < ACC_LO) begin
                m_acc  = ACC_LO;
                m_flag = 1'b1;
            end
        end
        m_first = 1'b0;
    endfunction

    function automatic void model_result(output logic [W-1:0] es, output logic ex);
        longint v;
        v  = m_acc;
        ex = m_flag;
        if (v > OUT_HI) begin
            v  = OUT_HI;
            ex = 1'b1;
        end else if (v < OUT_LO) begin
            v  = OUT_LO;
            ex = 1'b1;
        end
        es      = W'(v);
        m_first = 1'b1;
    endfunction

    function automatic longint rand_lane(input int mode);
        logic signed [W-1:0] t;
        case (mode)
            0:       t = W'(int'($urandom_range(0, 2000)) - 1000);
            1:       t = W'({$urandom, $urandom});
            2:       t = W'(OUT_HI - longint'($urandom_range(0, 1000)));
            default: t = W'(OUT_LO + longint'($urandom_range(0, 1000)));
        endcase
        return longint'(t);
    endfunction

    task automatic send_beat(input longint l0, input longint l1, input longint l2,
                             input longint l3, input bit last, input bit rand_en);
        bit took;
        took = 1'b0;
        bus.products[0] = W'(l0);
        bus.products[1] = W'(l1);
        bus.products[2] = W'(l2);
        bus.products[3] = W'(l3);
        bus.in_valid    = 1'b1;
        bus.in_last     = last;
        for (int k = 0; k < 64 && !took; k++) begin
            en   = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            took = en && bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        en           = 1'b1;
        check("beat_accepted", 64'(took), 64'(1));
        if (took) model_beat(l0 + l1 + l2 + l3);
    endtask

    task automatic wait_valid(output int lat);
        logic [W-1:0] es;
        logic         ex;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            check("in_ready_low_busy", 64'(bus.in_ready), 64'(0));
            tick();
            lat++;
        end
        check("out_valid_seen", 64'(bus.out_valid), 64'(1));
        model_result(es, ex);
        check("model_sum", 64'(bus.out_sum), 64'(es));
        check("model_sat", 64'(bus.out_sat), 64'(ex));
        check("in_ready_hold", 64'(bus.in_ready), 64'(0));
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_cleared", 64'(bus.out_valid), 64'(0));
        check("in_ready_back", 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=no finish required=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int nb;
        int mode;
        rst           = 1'b1;
        en            = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.products  = '0;
        bus.out_ready = 1'b0;

        // reset with en low must still take effect
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_sum", 64'(bus.out_sum), 64'(0));
        check("rst_out_sat", 64'(bus.out_sat), 64'(0));

        // single beat: result three cycles after acceptance
        send_beat(1, 2, 3, 4, 1'b1, 1'b0);
        check("single_lat_t2", 64'(bus.out_valid), 64'(0));
        wait_valid(lat);
        check("single_latency", 64'(lat), 64'(2));
        check("single_sum", 64'(bus.out_sum), 64'(10));
        check("single_sat", 64'(bus.out_sat), 64'(0));
        ack();

        // back-to-back beats summing to zero
        send_beat(1, 1, 1, 1, 1'b0, 1'b0);
        send_beat(2, 2, 2, 2, 1'b0, 1'b0);
        send_beat(-3, -3, -3, -3, 1'b1, 1'b0);
        check("b2b_ready_after_last", 64'(bus.in_ready), 64'(0));
        wait_valid(lat);
        check("b2b_latency", 64'(lat), 64'(2));
        check("b2b_sum", 64'(bus.out_sum), 64'(0));
        ack();

        // saturation at the positive limit, then a clean product
        send_beat(OUT_HI, OUT_HI, OUT_HI, OUT_HI, 1'b0, 1'b0);
        send_beat(OUT_HI, OUT_HI, OUT_HI, OUT_HI, 1'b1, 1'b0);
        wait_valid(lat);
        check("sat_sum", 64'(bus.out_sum), 64'(OUT_HI));
        check("sat_flag", 64'(bus.out_sat), 64'(1));
        ack();
        send_beat(0, 0, 0, 1, 1'b1, 1'b0);
        wait_valid(lat);
        check("after_sat_sum", 64'(bus.out_sum), 64'(1));
        check("after_sat_flag", 64'(bus.out_sat), 64'(0));
        ack();

        // en dropped for 5 cycles after the last beat
        send_beat(3, 0, 0, 0, 1'b1, 1'b0);
        en = 1'b0;
        repeat (5) tick();
        check("en_low_no_valid", 64'(bus.out_valid), 64'(0));
        en = 1'b1;
        wait_valid(lat);
        check("en_low_latency", 64'(lat), 64'(2));
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        for (int i = 0; i < n; i++) bus.products[i] = W'(100);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("hold_valid", 64'(bus.out_valid), 64'(1));
            check("hold_sum", 64'(bus.out_sum), 64'(3));
            check("hold_no_ready", 64'(bus.in_ready), 64'(0));
        end
        en            = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("hold_en_low_ack", 64'(bus.out_valid), 64'(1));
        en            = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        ack();
        send_beat(2, 0, 0, 0, 1'b1, 1'b0);
        wait_valid(lat);
        check("post_hold_sum", 64'(bus.out_sum), 64'(2));
        ack();

        // reset in the middle of a dot product discards it
        send_beat(1, 1, 1, 1, 1'b0, 1'b0);
        send_beat(2, 2, 2, 2, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        m_first = 1'b1;
        check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        for (int c = 0; c < 6; c++) begin
            tick();
            check("midrst_no_valid", 64'(bus.out_valid), 64'(0));
        end
        send_beat(5, 0, 0, 0, 1'b1, 1'b0);
        wait_valid(lat);
        check("midrst_sum", 64'(bus.out_sum), 64'(5));
        ack();

        // gapped beats; in_last without in_valid is ignored
        send_beat(7, 0, 0, 0, 1'b0, 1'b0);
        bus.in_last = 1'b1;
        tick();
        bus.in_last = 1'b0;
        check("stray_last_ignored", 64'(bus.in_ready), 64'(1));
        send_beat(0, 0, 0, -2, 1'b1, 1'b0);
        tick();
        wait_valid(lat);
        check("gap_sum", 64'(bus.out_sum), 64'(5));
        ack();

        // randomized products with random gaps and en drops
        for (int p = 0; p < 16; p++) begin
            nb   = $urandom_range(1, 5);
            mode = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin
                send_beat(rand_lane(mode), rand_lane(mode), rand_lane(mode),
                          rand_lane(mode), b == nb - 1, 1'b1);
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_valid(lat);
            ack();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/array_accum.md
ARRAY_ACCUM -- requirements
Module: array_accum

Interface
REQ-001 Parameter n, default 4, number of product lanes consumed per beat.
REQ-002 Parameter W, default 45, signed two's-complement data width per lane and of the result.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  global enable; when low, all registers hold and no handshake completes.
REQ-006 in_valid  input  1  products valid this cycle.
REQ-007 in_last  input  1  qualifies the final beat of a dot product; sampled only with in_valid.
REQ-008 products  input  [n-1:0][W-1:0]  lane products from the upstream array multiplier.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 out_valid  output  1  out_sum holds a completed dot product.
REQ-011 out_ready  input  1  downstream accepts out_sum.
REQ-012 out_sum  output  [W-1:0]  saturated signed dot-product result.
REQ-013 out_sat  output  1  set with out_valid when any saturation occurred during that dot product.

Function
REQ-014 A beat is accepted when en && in_valid && in_ready, all in the same cycle.
REQ-015 in_ready SHALL be 1 only in state ACCUM; accepted beats never stall inside the adder tree.
REQ-016 States: ACCUM (accepting beats), DRAIN (last beat in tree), HOLD (result presented).
REQ-017 ACCUM -> DRAIN on acceptance of a beat with in_last=1; otherwise stay in ACCUM.
REQ-018 The adder tree SHALL be 2 registered stages: stage 1 sums lane pairs at W+1 bits; stage 2 sums pairs to W+2 bits (n=4).
REQ-019 Accumulator register SHALL be W+3 bits signed, updated with each stage-2 output as it emerges; it is cleared when the first beat of a new dot product leaves stage 2.
REQ-020 Latency: last beat accepted in cycle t (with en held high) -> out_valid=1 in cycle t+3, with DRAIN -> HOLD transition on that edge.
REQ-021 out_sum SHALL be the accumulator saturated to [-2^(W-1), 2^(W-1)-1]; out_sat=1 iff the final accumulator value is out of W-bit range or any intermediate accumulation overflowed W+3 bits (sticky per dot product).
REQ-022 HOLD -> ACCUM on the cycle en && out_ready; out_valid, out_sum, out_sat stable while in HOLD and out_ready low.
REQ-023 A dot product of exactly one beat (in_valid && in_last on its first beat) SHALL be legal and produce the single-beat lane sum.
REQ-024 Beats with gaps (in_valid low between beats) SHALL accumulate identically to back-to-back beats.
REQ-025 en low in any state freezes tree stages, accumulator, state and outputs; latency in REQ-020 extends by the number of en-low cycles.
REQ-026 in_last without in_valid SHALL be ignored.

Reset
REQ-027 rst=1 at a posedge SHALL return state to ACCUM, clear both tree stages, accumulator and sticky saturation flag, regardless of en.
REQ-028 Outputs after reset: in_ready=1, out_valid=0, out_sum=0, out_sat=0.
REQ-029 Reset mid-dot-product or in HOLD SHALL discard all partial and pending results; no out_valid emitted for them.

Structure
REQ-030 Package array_accum_pkg SHALL hold W default, n default, accumulator width constant, and the state enum.
REQ-031 The 2-stage pipelined adder tree SHALL be a sub-module named add_tree_pipe, with the same clk, rst, en.
REQ-032 Ports SHALL be grouped into an interface with a modport, matching the multiplier stage so result connects directly to products.

Verification
REQ-033 Single beat, products {1,2,3,4}, in_last=1 at cycle t -> out_valid at t+3, out_sum=10, out_sat=0.
REQ-034 Three back-to-back beats {1,1,1,1},{2,2,2,2},{-3,-3,-3,-3}(last) -> out_sum=0, in_ready low from beat-3 acceptance until the out_ready handshake.
REQ-035 Four lanes of 2^44-1 for two beats -> out_sum=2^44-1, out_sat=1; next dot product {0,0,0,1} -> out_sum=1, out_sat=0.
REQ-036 Last beat accepted, en dropped for 5 cycles -> out_valid at t+8; out_ready held low 10 cycles -> out_sum stable, no new beat accepted.
REQ-037 rst pulsed after 2 of 3 beats -> no out_valid; following single beat {5,0,0,0} -> out_sum=5.
REQ-038 in_valid toggled 1,0,1,0 over a 2-beat product {7,0,0,0},{0,0,0,-2} -> out_sum=5.
